// File: rtl/rf_bank_controller_pkg.sv
// Shared types and defaults for the register-bank controller and its scrubber.
package p_hardisc;

    typedef enum logic [0:0] {
        RFS_WAIT  = 1'b0,
        RFS_CHECK = 1'b1
    } rf_scrub_state;

    localparam int RF_SCRUB_PERIOD_DEF = 16;

endpackage

// File: rtl/rf_bank_controller_if.sv
// Write/read/scrub signal bundle of rf_bank_controller; slave side is the bank itself.
interface rf_bank_controller_if #(
    parameter int W  = 32,
    parameter int N  = 32,
    parameter int RP = 2
);
    localparam int AW = $clog2(N);

    logic                   s_we_i;
    logic [AW-1:0]          s_wadd_i;
    logic [W-1:0]           s_wval_i;
    logic [RP-1:0][AW-1:0]  s_radd_i;
    logic [RP-1:0][W-1:0]   s_rval_o;
    logic                   s_scrub_en_i;
    logic                   s_err_clr_i;
    logic                   s_err_o;
    logic [AW-1:0]          s_err_add_o;
    logic [AW-1:0]          s_scrub_ptr_o;

    modport master (
        output s_we_i, s_wadd_i, s_wval_i, s_radd_i, s_scrub_en_i, s_err_clr_i,
        input  s_rval_o, s_err_o, s_err_add_o, s_scrub_ptr_o
    );

    modport slave (
        input  s_we_i, s_wadd_i, s_wval_i, s_radd_i, s_scrub_en_i, s_err_clr_i,
        output s_rval_o, s_err_o, s_err_add_o, s_scrub_ptr_o
    );

endinterface

// File: rtl/rf_bank_controller_scrubber.sv
// Background parity scrubber: walks entries 1..N-1 every SCRUB_PERIOD+1 cycles and
// latches the first parity mismatch as a sticky error.
module rf_scrubber
    import p_hardisc::*;
#(
    parameter int W            = 32,
    parameter int N            = 32,
    parameter int SCRUB_PERIOD = RF_SCRUB_PERIOD_DEF,
    localparam int AW          = $clog2(N)
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    input  logic          s_scrub_en_i,
    input  logic          s_err_clr_i,
    input  logic          s_we_i,
    input  logic [AW-1:0] s_wadd_i,
    input  logic [W-1:0]  s_chk_data_i,
    input  logic          s_chk_par_i,
    output logic          s_err_o,
    output logic [AW-1:0] s_err_add_o,
    output logic [AW-1:0] s_scrub_ptr_o
);

    localparam int              CW       = $clog2(SCRUB_PERIOD + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCRUB_PERIOD - 1);
    localparam logic [AW-1:0]   PTR_LAST = AW'(N - 1);
    localparam logic [AW-1:0]   PTR_FIRST = AW'(1);

    rf_scrub_state  state_d, state_q;
    logic [CW-1:0]  cnt_d, cnt_q;
    logic [AW-1:0]  ptr_d, ptr_q;
    logic           err_d, err_q;
    logic [AW-1:0]  err_add_d, err_add_q;
    logic           mismatch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        err_add_d = err_add_q;
        mismatch  = 1'b0;
        if (s_err_clr_i) begin
            err_d     = 1'b0;
            err_add_d = '0;
        end
        case (state_q)
            RFS_WAIT: begin
                if (s_scrub_en_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = RFS_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RFS_CHECK: begin
                // An entry being rewritten this cycle is not judged on its old contents.
                mismatch = (s_chk_par_i != ^s_chk_data_i) && !(s_we_i && (s_wadd_i == ptr_q));
                if (mismatch && (!err_q || s_err_clr_i)) begin
                    err_d     = 1'b1;
                    err_add_d = ptr_q;
                end
                ptr_d   = (ptr_q == PTR_LAST) ? PTR_FIRST : ptr_q + 1'b1;
                state_d = RFS_WAIT;
            end
            default: state_d = RFS_WAIT;
        endcase
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q   <= RFS_WAIT;
            cnt_q     <= '0;
            ptr_q     <= PTR_FIRST;
            err_q     <= 1'b0;
            err_add_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            err_add_q <= err_add_d;
        end
    end

    assign s_err_o       = err_q;
    assign s_err_add_o   = err_add_q;
    assign s_scrub_ptr_o = ptr_q;

endmodule

// File: rtl/rf_bank_controller.sv
// W x N register bank, RP combinational read ports with write forwarding, entry 0 reads zero.
// Optional parity scrubber is built when RF_SCRUB_EN is defined.
module rf_bank_controller
    import p_hardisc::*;
#(
    parameter int W            = 32,
    parameter int N            = 32,
    parameter int RP           = 2,
    parameter int SCRUB_PERIOD = RF_SCRUB_PERIOD_DEF
) (
    input  logic                 s_clk_i,
    input  logic                 s_resetn_i,
    rf_bank_controller_if.slave  bus
);

    localparam int AW = $clog2(N);

    logic [N-1:0][W-1:0]   mem_q;
    logic [RP-1:0][W-1:0]  rval;
    logic                  wr_en;

    assign wr_en = bus.s_we_i && (bus.s_wadd_i != '0);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            mem_q <= '0;
        end else if (wr_en) begin
            mem_q[bus.s_wadd_i] <= bus.s_wval_i;
        end
    end

    always_comb begin
        rval = '0;
        for (int k = 0; k < RP; k++) begin
            if (bus.s_radd_i[k] == '0) begin
                rval[k] = '0;
            end else if (wr_en && (bus.s_wadd_i == bus.s_radd_i[k])) begin
                rval[k] = bus.s_wval_i;
            end else begin
                rval[k] = mem_q[bus.s_radd_i[k]];
            end
        end
    end

    assign bus.s_rval_o = rval;

`ifdef RF_SCRUB_EN
    logic [N-1:0]   par_q;
    logic [AW-1:0]  scrub_ptr;

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            par_q <= '0;
        end else if (wr_en) begin
            par_q[bus.s_wadd_i] <= ^bus.s_wval_i;
        end
    end

    rf_scrubber #(
        .W            (W),
        .N            (N),
        .SCRUB_PERIOD (SCRUB_PERIOD)
    ) u_scrubber (
        .s_clk_i       (s_clk_i),
        .s_resetn_i    (s_resetn_i),
        .s_scrub_en_i  (bus.s_scrub_en_i),
        .s_err_clr_i   (bus.s_err_clr_i),
        .s_we_i        (bus.s_we_i),
        .s_wadd_i      (bus.s_wadd_i),
        .s_chk_data_i  (mem_q[scrub_ptr]),
        .s_chk_par_i   (par_q[scrub_ptr]),
        .s_err_o       (bus.s_err_o),
        .s_err_add_o   (bus.s_err_add_o),
        .s_scrub_ptr_o (scrub_ptr)
    );

    assign bus.s_scrub_ptr_o = scrub_ptr;
`else
    logic unused_scrub_inputs;
    assign unused_scrub_inputs = bus.s_scrub_en_i ^ bus.s_err_clr_i;

    assign bus.s_err_o       = 1'b0;
    assign bus.s_err_add_o   = '0;
    assign bus.s_scrub_ptr_o = '0;
`endif

endmodule

// File: tb/tb_rf_bank_controller.sv
// Scoreboard bench for rf_bank_controller (N=8, SCRUB_PERIOD=3); scrub phase runs when RF_SCRUB_EN is defined.
module tb_rf_bank_controller;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int RP = 2;
    localparam int SP = 3;

`ifdef RF_SCRUB_EN
    localparam logic [2:0] PTR_RST = 3'd1;
`else
    localparam logic [2:0] PTR_RST = 3'd0;
`endif

    localparam int K_R0 = 0, K_R1 = 1, K_ERR = 2, K_ADD = 3, K_PTR = 4;

    typedef struct {
        int          tag;
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tick = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    item_t sb[$];

    rf_bank_controller_if #(.W(W), .N(N), .RP(RP)) bus ();

    rf_bank_controller #(.W(W), .N(N), .RP(RP), .SCRUB_PERIOD(SP)) dut (
        .s_clk_i    (clk),
        .s_resetn_i (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: compare every expectation tagged for this cycle at the falling edge.
    initial begin
        item_t       it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= tick) begin
                it = sb.pop_front();
                case (it.kind)
                    K_R0:    act = bus.s_rval_o[0];
                    K_R1:    act = bus.s_rval_o[1];
                    K_ERR:   act = {31'd0, bus.s_err_o};
                    K_ADD:   act = {29'd0, bus.s_err_add_o};
                    default: act = {29'd0, bus.s_scrub_ptr_o};
                endcase
                n_chk++;
                if (it.tag == tick && act === it.exp) n_pass++;
                else $display("FAIL %s: got %h, expected %h (tag %0d, tick %0d)", it.name, act, it.exp, it.tag, tick);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic expect_v(input int kind, input logic [31:0] exp, input string name);
        item_t it;
        it.tag  = tick;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            bus.s_we_i      = 1'b0;
            bus.s_err_clr_i = 1'b0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        bus.s_we_i   = 1'b1;
        bus.s_wadd_i = a;
        bus.s_wval_i = v;
    endtask

    task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
        bus.s_radd_i[0] = a0;
        bus.s_radd_i[1] = a1;
    endtask

    task automatic expect_err(input logic e, input logic [2:0] a, input string name);
        expect_v(K_ERR, {31'd0, e}, {name, "_err"});
        expect_v(K_ADD, {29'd0, a}, {name, "_add"});
    endtask

`ifdef RF_SCRUB_EN
    task automatic flip(input int idx, input int b);
        dut.mem_q[idx][b] = ~dut.mem_q[idx][b];
    endtask
`endif

    initial begin
        bus.s_we_i       = 1'b0;
        bus.s_wadd_i     = '0;
        bus.s_wval_i     = '0;
        bus.s_radd_i     = '0;
        bus.s_scrub_en_i = 1'b0;
        bus.s_err_clr_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Read/write/forwarding with the scrubber idle.
        goto(0);
        rd(3'd5, 3'd5);
        expect_err(1'b0, 3'd0, "rst");
        expect_v(K_PTR, {29'd0, PTR_RST}, "rst_ptr");
        expect_v(K_R0, 32'h0, "rst_r0");
        expect_v(K_R1, 32'h0, "rst_r1");
        goto(1);
        wr(3'd5, 32'hDEADBEEF);
        goto(2);
        rd(3'd5, 3'd5);
        expect_v(K_R0, 32'hDEADBEEF, "x5_r0");
        expect_v(K_R1, 32'hDEADBEEF, "x5_r1");
        goto(3);
        wr(3'd0, 32'h00001234);
        rd(3'd0, 3'd0);
        expect_v(K_R0, 32'h0, "x0_fwd_r0");
        expect_v(K_R1, 32'h0, "x0_fwd_r1");
        goto(4);
        rd(3'd0, 3'd5);
        expect_v(K_R0, 32'h0, "x0_r0");
        expect_v(K_R1, 32'hDEADBEEF, "x5_keep_r1");
        goto(5);
        wr(3'd7, 32'hA5A5A5A5);
        rd(3'd6, 3'd7);
        expect_v(K_R0, 32'h0, "x6_r0");
        expect_v(K_R1, 32'hA5A5A5A5, "x7_fwd_r1");
        goto(6);
        rd(3'd7, 3'd7);
        expect_v(K_R0, 32'hA5A5A5A5, "x7_r0");
        expect_v(K_R1, 32'hA5A5A5A5, "x7_r1");
        expect_v(K_PTR, {29'd0, PTR_RST}, "ptr_idle");
        goto(7);
        wr(3'd5, 32'h11111111);
        rd(3'd5, 3'd5);
        expect_v(K_R0, 32'h11111111, "x5_ovr_fwd_r0");
        expect_v(K_R1, 32'h11111111, "x5_ovr_fwd_r1");
        goto(8);
        rd(3'd5, 3'd7);
        expect_v(K_R0, 32'h11111111, "x5_ovr_r0");
        expect_v(K_R1, 32'hA5A5A5A5, "x7_keep_r1");
        goto(9);

`ifdef RF_SCRUB_EN
        // Scrubber phase: enable held from reset release.
        rst_n = 1'b0;
        bus.s_scrub_en_i = 1'b1;
        bus.s_radd_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int c = 0; c < 32; c++) begin
            goto(c);
            expect_v(K_PTR, 32'(1 + ((c / 4) % 7)), "sweep_ptr");
            if (c % 4 == 0) expect_v(K_ERR, 32'd0, "sweep_err");
        end
        goto(32);
        flip(3, 0);
        goto(39);
        expect_err(1'b0, 3'd0, "pre_x3");
        goto(40);
        expect_err(1'b1, 3'd3, "det_x3");
        goto(41);
        flip(5, 7);
        goto(48);
        expect_err(1'b1, 3'd3, "sticky_x5");
        goto(50);
        bus.s_err_clr_i = 1'b1;
        goto(51);
        expect_err(1'b0, 3'd0, "clr1");
        goto(52);
        wr(3'd3, 32'h0);
        goto(53);
        wr(3'd5, 32'h0);
        goto(54);
        flip(4, 12);
        goto(71);
        bus.s_err_clr_i = 1'b1;
        goto(72);
        expect_err(1'b1, 3'd4, "clr_vs_set");
        goto(73);
        bus.s_err_clr_i = 1'b1;
        goto(74);
        expect_err(1'b0, 3'd0, "clr2");
        goto(75);
        wr(3'd4, 32'h0);
        goto(76);
        flip(2, 1);
        goto(91);
        wr(3'd2, 32'h00000001);
        goto(92);
        rd(3'd2, 3'd3);
        expect_err(1'b0, 3'd0, "skip_x2");
        expect_v(K_R0, 32'h00000001, "x2_rewr_r0");
        expect_v(K_R1, 32'h0, "x3_rewr_r1");
        expect_v(K_PTR, 32'd3, "ptr_after_x2");
        goto(93);
        bus.s_scrub_en_i = 1'b0;
        goto(102);
        expect_v(K_PTR, 32'd3, "freeze_ptr");
        goto(103);
        bus.s_scrub_en_i = 1'b1;
        goto(105);
        expect_v(K_PTR, 32'd3, "resume_ptr_a");
        goto(106);
        expect_v(K_PTR, 32'd4, "resume_ptr_b");
        goto(107);
        flip(4, 0);
        goto(109);
        expect_v(K_PTR, 32'd4, "midchk_ptr");
        #2 rst_n = 1'b0;
        expect_err(1'b0, 3'd0, "async_rst");
        expect_v(K_PTR, 32'd1, "async_rst_ptr");
        @(posedge clk);
        #1;
        expect_err(1'b0, 3'd0, "rst_hold");
        expect_v(K_PTR, 32'd1, "rst_hold_ptr");
        rst_n = 1'b1;
`endif

        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
